// File: rtl/gpio_irq_sync_pkg.sv
// Shared types and defaults for the GPIO input conditioning block.
package gpio_irq_sync_pkg;

  localparam int unsigned GpioSyncStages    = 2;
  localparam int unsigned GpioDebounceWidth = 8;

  typedef enum logic [1:0] {
    EdgeOff  = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10,
    EdgeBoth = 2'b11
  } edge_mode_e;

  typedef enum logic {
    FiltStable,
    FiltCounting
  } filt_state_e;

endpackage

// File: rtl/gpio_irq_sync_if.sv
// Configuration, raw inputs and interrupt outputs of gpio_irq_sync.
interface gpio_irq_sync_if #(
  parameter int unsigned NumChannels = 16,
  parameter int unsigned CntWidth    = 8
) ();

  logic [NumChannels-1:0]   async_i;
  logic [CntWidth-1:0]      threshold_i;
  logic [2*NumChannels-1:0] edge_mode_i;
  logic [NumChannels-1:0]   clear_i;
  logic [NumChannels-1:0]   sync_o;
  logic [NumChannels-1:0]   pending_o;
  logic                     irq_o;

  modport master (
    output async_i, threshold_i, edge_mode_i, clear_i,
    input  sync_o, pending_o, irq_o
  );

  modport slave (
    input  async_i, threshold_i, edge_mode_i, clear_i,
    output sync_o, pending_o, irq_o
  );

endinterface

// File: rtl/gpio_irq_sync_ch.sv
// One channel: synchroniser, debounce filter, edge detector, sticky pending flag.
module gpio_irq_sync_ch
  import gpio_irq_sync_pkg::*;
#(
  parameter int unsigned SyncStages = GpioSyncStages,
  parameter int unsigned CntWidth   = GpioDebounceWidth,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                async_i,
  input  logic [CntWidth-1:0] threshold_i,
  input  edge_mode_e          edge_mode_i,
  input  logic                clear_i,
  output logic                sync_o,
  output logic                pending_o
);

  logic [SyncStages-1:0] sync_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  pending_q, pending_d;
  logic                  s, upd, hit;
  filt_state_e           state;

  assign s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= {SyncStages{ResetValue}};
      cnt_q     <= '0;
      level_q   <= ResetValue;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], async_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  // Filter state is implied by s vs. the filtered level, so it needs no flop of its own.
  always_comb begin
    state   = (s == level_q) ? FiltStable : FiltCounting;
    cnt_d   = '0;
    level_d = level_q;
    upd     = 1'b0;
    hit     = 1'b0;
    unique case (state)
      FiltStable: cnt_d = '0;
      FiltCounting: begin
        if (cnt_q >= threshold_i) begin
          upd     = 1'b1;
          level_d = s;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = '0;
    endcase
    unique case (edge_mode_i)
      EdgeOff:  hit = 1'b0;
      EdgeRise: hit = upd & s;
      EdgeFall: hit = upd & ~s;
      EdgeBoth: hit = upd;
      default:  hit = 1'b0;
    endcase
    // Set dominates clear so an event coinciding with a clear is kept.
    pending_d = (pending_q & ~clear_i) | hit;
  end

  assign sync_o    = level_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/gpio_irq_sync.sv
// N-channel input synchroniser / glitch filter with edge interrupts.
module gpio_irq_sync
  import gpio_irq_sync_pkg::*;
#(
  parameter int unsigned NumChannels = 16,
  parameter int unsigned SyncStages  = GpioSyncStages,
  parameter int unsigned CntWidth    = GpioDebounceWidth,
  parameter logic        ResetValue  = 1'b0
) (
  input logic           clk_i,
  input logic           rst_ni,
  gpio_irq_sync_if.slave gpio
);

  logic [NumChannels-1:0] level;
  logic [NumChannels-1:0] pend;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    gpio_irq_sync_ch #(
      .SyncStages (SyncStages),
      .CntWidth   (CntWidth),
      .ResetValue (ResetValue)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .async_i     (gpio.async_i[i]),
      .threshold_i (gpio.threshold_i),
      .edge_mode_i (edge_mode_e'(gpio.edge_mode_i[2*i +: 2])),
      .clear_i     (gpio.clear_i[i]),
      .sync_o      (level[i]),
      .pending_o   (pend[i])
    );
  end

  assign gpio.sync_o    = level;
  assign gpio.pending_o = pend;
  assign gpio.irq_o     = |pend;

endmodule

// File: tb/tb_gpio_irq_sync.sv
// Randomised and directed bench for gpio_irq_sync against a run-length reference model.
module tb_gpio_irq_sync;
  import gpio_irq_sync_pkg::*;

  localparam int N  = 16;
  localparam int SS = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpio_irq_sync_if #(.NumChannels(N), .CntWidth(CW)) bus ();

  gpio_irq_sync #(
    .NumChannels (N),
    .SyncStages  (SS),
    .CntWidth    (CW),
    .ResetValue  (1'b0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .gpio   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: inputs seen at the pins per edge, filtered level, pending, mismatch run length.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_sync, m_pend;
  int           run[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = '0;
    m_pend = '0;
    hist.delete();
    for (int c = 0; c < N; c++) run[c] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    logic [1:0]   mode;
    logic         ev_r, ev_f, set;
    s = (hist.size() >= SS) ? hist[hist.size()-SS] : '0;
    hist.push_back(bus.async_i);
    if (hist.size() > SS) void'(hist.pop_front());
    for (int c = 0; c < N; c++) begin
      ev_r = 1'b0;
      ev_f = 1'b0;
      if (s[c] != m_sync[c]) begin
        run[c]++;
        if (run[c] > int'(bus.threshold_i)) begin
          m_sync[c] = s[c];
          run[c]    = 0;
          ev_r      = s[c];
          ev_f      = !s[c];
        end
      end else begin
        run[c] = 0;
      end
      mode      = bus.edge_mode_i[2*c +: 2];
      set       = (mode[0] && ev_r) || (mode[1] && ev_f);
      m_pend[c] = (m_pend[c] && !bus.clear_i[c]) || set;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("sync", 32'(bus.sync_o), 32'(m_sync));
    check("pend", 32'(bus.pending_o), 32'(m_pend));
    check("irq", 32'(bus.irq_o), 32'(|m_pend));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_mode(input int ch, input edge_mode_e m);
    bus.edge_mode_i[2*ch +: 2] = m;
  endtask

  task automatic pulse_clear(input int ch);
    bus.clear_i[ch] = 1'b1;
    tick();
    bus.clear_i = '0;
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.async_i     = '0;
    bus.threshold_i = '0;
    bus.edge_mode_i = '0;
    bus.clear_i     = '0;
    model_reset();
    ticks(2);
    check("rst_sync", 32'(bus.sync_o), 32'h0);
    check("rst_irq", 32'(bus.irq_o), 32'h0);
    rst_n = 1'b1;

    // All channels high with bypass filter: 3-cycle latency, no pending.
    bus.async_i = 16'hFFFF;
    ticks(2);
    check("lat0_early", 32'(bus.sync_o), 32'h0);
    tick();
    check("lat0", 32'(bus.sync_o), 32'hFFFF);
    check("lat0_pend", 32'(bus.pending_o), 32'h0);

    // Settle low with T=4, then glitch/pulse on channel 0 (rising mode).
    bus.threshold_i = 8'd4;
    bus.async_i     = '0;
    ticks(12);
    set_mode(0, EdgeRise);
    bus.async_i[0] = 1'b1;
    ticks(3);
    bus.async_i[0] = 1'b0;
    ticks(10);
    check("glitch_sync", 32'(bus.sync_o[0]), 32'h0);
    check("glitch_pend", 32'(bus.pending_o[0]), 32'h0);
    bus.async_i[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.sync_o[0] && n < 20);
    check("lat_t4", 32'(n), 32'd7);
    check("lat_t4_pend", 32'(bus.pending_o[0]), 32'h1);
    check("lat_t4_irq", 32'(bus.irq_o), 32'h1);
    ticks(3);
    bus.async_i[0] = 1'b0;
    ticks(10);
    pulse_clear(0);
    check("clr0", 32'(bus.pending_o[0]), 32'h0);

    // Channel 3 both edges, T=2.
    bus.threshold_i = 8'd2;
    set_mode(3, EdgeBoth);
    for (int k = 0; k < 4; k++) begin
      bus.async_i[3] = ~bus.async_i[3];
      ticks(20);
      check("both_pend", 32'(bus.pending_o[3]), 32'h1);
      pulse_clear(3);
      check("both_clr", 32'(bus.pending_o[3]), 32'h0);
    end

    // Channel 5 falling: clear coincides with the updating edge.
    set_mode(5, EdgeFall);
    bus.async_i[5] = 1'b1;
    ticks(10);
    bus.async_i[5] = 1'b0;
    ticks(4);
    bus.clear_i[5] = 1'b1;
    tick();
    bus.clear_i = '0;
    check("setclr_sync", 32'(bus.sync_o[5]), 32'h0);
    check("setclr_pend", 32'(bus.pending_o[5]), 32'h1);

    // Saturating count at T=255, then lowering T mid-count.
    bus.threshold_i = 8'd255;
    set_mode(7, EdgeRise);
    bus.async_i[7] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.sync_o[7] && n < 300);
    check("lat_t255", 32'(n), 32'd258);
    check("lat_t255_pend", 32'(bus.pending_o[7]), 32'h1);
    bus.async_i[7] = 1'b0;
    ticks(50);
    check("t255_hold", 32'(bus.sync_o[7]), 32'h1);
    bus.threshold_i = 8'd1;
    tick();
    check("t_drop", 32'(bus.sync_o[7]), 32'h0);

    // Asynchronous reset while counting with pending flags set.
    bus.threshold_i = 8'd10;
    set_mode(9, EdgeRise);
    bus.async_i[9] = 1'b1;
    ticks(6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sync", 32'(bus.sync_o), 32'h0);
    check("arst_pend", 32'(bus.pending_o), 32'h0);
    check("arst_irq", 32'(bus.irq_o), 32'h0);
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.sync_o[9] && n < 40);
    check("post_rst_lat", 32'(n), 32'd13);
    check("post_rst_pend", 32'(bus.pending_o[9]), 32'h1);

    // Random traffic: sparse toggles, random clears, periodic mode/threshold changes.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        bus.threshold_i = CW'($urandom_range(0, 5));
        bus.edge_mode_i = 32'($urandom);
      end
      bus.async_i = bus.async_i ^ N'($urandom & $urandom & $urandom);
      bus.clear_i = N'($urandom & $urandom & $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
